// File: rtl/mm_line_responder.sv
// mm_line_responder: behavioural main memory serving cache line fills and evictions after fixed latencies
// Ports: clk, reset (async, active-high); mm_a line address, index in [IDX_BITS+4:5];
//        mm_be/mm_wd eviction byte enables and data; mm_write_d/mm_read_d command strobes;
//        mm_rd/mm_readdata_valid fill data and one-cycle strobe; mm_busy service flag; mm_err sticky protocol error
module mm_line_responder #(
    parameter int LINE_BITS = 256,
    parameter int IDX_BITS  = 10,
    parameter int RD_LAT    = 4,
    parameter int WR_LAT    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            mm_a,
    input  logic [LINE_BITS/8-1:0] mm_be,
    input  logic [LINE_BITS-1:0]   mm_wd,
    input  logic                   mm_write_d,
    input  logic                   mm_read_d,
    output logic [LINE_BITS-1:0]   mm_rd,
    output logic                   mm_readdata_valid,
    output logic                   mm_busy,
    output logic                   mm_err
);
    localparam int NB = LINE_BITS / 8;
    localparam int CW = $clog2((RD_LAT > WR_LAT ? RD_LAT : WR_LAT) + 1);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;
    state_t state, nstate;
    logic [CW-1:0] cnt, ncnt;
    logic rd_pend, npend;
    logic [IDX_BITS-1:0] idx, a_idx, r_idx;
    logic [NB-1:0] be_r;
    logic [LINE_BITS-1:0] wd_r, merged, r_data;
    logic [LINE_BITS-1:0] mem [2**IDX_BITS];
    logic cmd, take, commit, strobe, unused_a;
    assign a_idx = mm_a[IDX_BITS+4:5];
    assign unused_a = ^{mm_a[31:IDX_BITS+5], mm_a[4:0]};
    assign cmd = mm_read_d | mm_write_d;
    // the strobe cycle and an unchained commit cycle already report not-busy, so they accept new work
    assign take = cmd & ~mm_busy;
    assign commit = state == WR_WAIT && cnt == '0;
    always_comb begin
        merged = mem[idx];
        for (int i = 0; i < NB; i++)
            if (be_r[i]) merged[8*i +: 8] = wd_r[8*i +: 8];
    end
    // fill data is captured on the edge entering the strobe cycle; forward a commit landing on that same edge
    assign r_idx = take ? a_idx : idx;
    assign r_data = (commit && r_idx == idx) ? merged : mem[r_idx];
    always_comb begin
        nstate = state;
        ncnt = cnt;
        npend = rd_pend;
        if (take) begin
            nstate = mm_write_d ? WR_WAIT : RD_WAIT;
            ncnt = mm_write_d ? CW'(WR_LAT - 1) : CW'(RD_LAT - 1);
            npend = mm_write_d & mm_read_d;
        end else if (commit && rd_pend) begin
            nstate = RD_WAIT;
            ncnt = CW'(RD_LAT - 1);
            npend = 1'b0;
        end else if (state != IDLE) begin
            nstate = cnt == '0 ? IDLE : state;
            ncnt = cnt == '0 ? cnt : cnt - 1'b1;
        end
    end
    assign strobe = nstate == RD_WAIT && ncnt == '0;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            rd_pend <= 1'b0;
            idx <= '0;
            be_r <= '0;
            wd_r <= '0;
            mm_rd <= '0;
            mm_readdata_valid <= 1'b0;
            mm_busy <= 1'b0;
            mm_err <= 1'b0;
        end else begin
            state <= nstate;
            cnt <= ncnt;
            rd_pend <= npend;
            if (take) begin
                idx <= a_idx;
                be_r <= mm_be;
                wd_r <= mm_wd;
            end
            mm_readdata_valid <= strobe;
            if (strobe) mm_rd <= r_data;
            mm_busy <= nstate != IDLE && !(ncnt == '0 && !(nstate == WR_WAIT && npend));
            mm_err <= mm_err | (cmd & mm_busy);
        end
    always_ff @(posedge clk)
        if (commit) mem[idx] <= merged;
endmodule

// File: tb/tb_mm_line_responder.sv
// tb_mm_line_responder: directed and random checks of mm_line_responder against a line-array model
module tb_mm_line_responder;
    localparam int LB = 256, IB = 10, RL = 4, WL = 2, NB = LB / 8;
    logic clk = 1'b0, reset = 1'b1;
    logic [31:0] mm_a = '0;
    logic [NB-1:0] mm_be = '0;
    logic [LB-1:0] mm_wd = '0;
    logic mm_write_d = 1'b0, mm_read_d = 1'b0;
    logic [LB-1:0] mm_rd;
    logic mm_readdata_valid, mm_busy, mm_err;
    logic [LB-1:0] ref_mem [1 << IB];
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    mm_line_responder #(.LINE_BITS(LB), .IDX_BITS(IB), .RD_LAT(RL), .WR_LAT(WL)) dut (
        .clk(clk), .reset(reset), .mm_a(mm_a), .mm_be(mm_be), .mm_wd(mm_wd),
        .mm_write_d(mm_write_d), .mm_read_d(mm_read_d), .mm_rd(mm_rd),
        .mm_readdata_valid(mm_readdata_valid), .mm_busy(mm_busy), .mm_err(mm_err)
    );
    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask
    task automatic checkw(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    function automatic logic [LB-1:0] merge(input logic [LB-1:0] old, input logic [LB-1:0] wd, input logic [NB-1:0] be);
        merge = old;
        for (int i = 0; i < NB; i++)
            if (be[i]) merge[8*i +: 8] = wd[8*i +: 8];
    endfunction
    function automatic logic [31:0] addr(input int idx, input logic [31:0] junk);
        addr = {junk[31:IB+5], idx[IB-1:0], junk[4:0]};
    endfunction
    // one command from an idle cycle; checks strobe, busy and data every cycle up to completion, then one quiet cycle
    task automatic xact(input logic rd, input logic wr, input int idx, input logic [NB-1:0] be,
                        input logic [LB-1:0] wd, input logic [31:0] junk);
        int lat;
        lat = (rd && wr) ? WL + RL : (rd ? RL : WL);
        mm_a = addr(idx, junk);
        mm_read_d = rd;
        mm_write_d = wr;
        mm_be = be;
        mm_wd = wd;
        if (wr) ref_mem[idx] = merge(ref_mem[idx], wd, be);
        tick;
        mm_read_d = 1'b0;
        mm_write_d = 1'b0;
        mm_be = ~be;
        mm_wd = ~wd;
        mm_a = ~mm_a;
        for (int k = 1; k <= lat; k++) begin
            check1("valid", mm_readdata_valid, rd && k == lat);
            check1("busy", mm_busy, k < lat);
            if (rd && k == lat) checkw("rdata", mm_rd, ref_mem[idx]);
            if (k < lat) tick;
        end
        tick;
        check1("post_valid", mm_readdata_valid, 1'b0);
        check1("post_busy", mm_busy, 1'b0);
        check1("err_clear", mm_err, 1'b0);
    endtask
    initial begin
        logic [LB-1:0] v;
        for (int i = 0; i < (1 << IB); i++) begin
            for (int w = 0; w < LB / 32; w++) v[32*w +: 32] = $urandom();
            ref_mem[i] = v;
            dut.mem[i] = v;
        end
        ref_mem[5] = {NB{8'hA5}};
        dut.mem[5] = {NB{8'hA5}};
        ref_mem[3] = '0;
        dut.mem[3] = '0;
        tick;
        tick;
        checkw("reset_rd", mm_rd, '0);
        check1("reset_valid", mm_readdata_valid, 1'b0);
        check1("reset_busy", mm_busy, 1'b0);
        check1("reset_err", mm_err, 1'b0);
        reset = 1'b0;
        tick;
        mm_a = 32'h000000A0;
        xact(1'b1, 1'b0, 5, '0, '0, 32'h0);
        checkw("line5_const", mm_rd, {NB{8'hA5}});
        xact(1'b0, 1'b1, 7, '1, {NB{8'h11}}, 32'h0);
        xact(1'b1, 1'b0, 7, '0, '0, 32'hFFFF_801F);
        checkw("line7_const", mm_rd, {NB{8'h11}});
        xact(1'b0, 1'b1, 3, 32'h0000000F, '1, 32'h0);
        xact(1'b1, 1'b0, 3, '0, '0, 32'h0);
        checkw("partial_const", mm_rd, {{(NB-4){8'h00}}, {4{8'hFF}}});
        xact(1'b1, 1'b1, 9, '1, {NB{8'h5A}}, 32'h0);
        checkw("both_const", mm_rd, {NB{8'h5A}});
        for (int n = 0; n < 30; n++) begin
            int kind;
            logic [LB-1:0] wd;
            kind = $urandom_range(0, 2);
            for (int w = 0; w < LB / 32; w++) wd[32*w +: 32] = $urandom();
            xact(kind != 1, kind != 0, $urandom_range(0, 15), $urandom(), wd, $urandom());
        end
        mm_a = addr(20, 32'h0);
        mm_read_d = 1'b1;
        tick;
        check1("err_busy", mm_busy, 1'b1);
        mm_a = addr(21, 32'h0);
        tick;
        mm_read_d = 1'b0;
        check1("err_set", mm_err, 1'b1);
        check1("err_valid2", mm_readdata_valid, 1'b0);
        tick;
        check1("err_valid3", mm_readdata_valid, 1'b0);
        tick;
        check1("err_valid4", mm_readdata_valid, 1'b1);
        checkw("err_rdata", mm_rd, ref_mem[20]);
        tick;
        check1("err_single", mm_readdata_valid, 1'b0);
        check1("err_sticky", mm_err, 1'b1);
        tick;
        check1("err_sticky2", mm_err, 1'b1);
        mm_a = addr(30, 32'h0);
        mm_read_d = 1'b1;
        tick;
        mm_read_d = 1'b0;
        tick;
        #2 reset = 1'b1;
        #1;
        check1("rst_busy", mm_busy, 1'b0);
        check1("rst_valid", mm_readdata_valid, 1'b0);
        check1("rst_err", mm_err, 1'b0);
        checkw("rst_rd", mm_rd, '0);
        tick;
        #2 reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick;
            check1("rst_no_valid", mm_readdata_valid, 1'b0);
        end
        xact(1'b1, 1'b0, 30, '0, '0, 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
